fetch_queue_sched: RTL and testbench
====================================

Name: fetch_queue_sched

Overview:
- Schedules the 6-slot fetch bundle into the instruction queue.
- Each cycle it picks up to WAYS pending slots in ascending slot order. The number picked is limited by free queue entries and by debug single-step. The pick stops after the first slot that is a jump/call or a predicted-taken branch.
- It owns slot-valid tracking, the queue tail pointer and the free-entry count, and tells fetch when the bundle is fully consumed.
- It sits between the fetch/predecode stage and the queue allocation logic.

Parameters:
- WAYS, 2: maximum slots enqueued per cycle, legal range 1..6.
- QENTRIES, 16: instruction queue depth, power of two, minimum 8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- branchmiss  in  1  flush: suppresses enqueue and restarts the bundle
- phit  in  1  fetch bundle is valid this cycle
- ip_mask  in  6  slots at or after the fetch entry point
- slot_jc  in  6  slot is a jump/call
- take_branch  in  6  slot is a predicted-taken branch
- debug_on  in  1  single-issue mode
- commit_cnt  in  3  queue entries freed this cycle, 0..6
- slotv  out  6  registered per-slot "not yet enqueued" flags
- qv  out  WAYS  way w enqueues a slot this cycle
- qslot  out  3*WAYS  slot index assigned to each way
- qtail  out  WAYS*$clog2(QENTRIES)  queue index written by each way
- free_cnt  out  $clog2(QENTRIES)+1  registered count of free queue entries
- bundle_done  out  1  fetch may advance; asserted in the same cycle as the final enqueue

Behaviour:
- Reset values: slotv=6'h3F, tail=0, free_cnt=QENTRIES. With rst high, qv=0 and bundle_done=0.
- pat = slotv & {6{phit}} & ip_mask.
- lim = min(WAYS, free_cnt, debug_on ? 1 : WAYS).
- Selection (combinational):
  - Walk the set bits of pat from slot 0 upward and take at most lim of them; k = number taken.
  - If a taken slot has slot_jc|take_branch set, no later slot is taken.
  - Way w, for w<k, gets qv[w]=1, qslot[w] = w-th taken slot index, qtail[w] = (tail+w) mod QENTRIES.
  - Ways with w>=k drive qv=0; their qslot and qtail are don't-care, driven 0.
- bundle_done = phit & !branchmiss & (pat==0 | all set bits of pat taken | a taken slot is jc/taken-branch).
- Registered update on clk, when not in reset:
  - branchmiss=1: slotv<=6'h3F and k is forced to 0. tail holds. free_cnt still adds commit_cnt.
  - else if bundle_done: slotv<=6'h3F.
  - else: the taken slotv bits are cleared.
  - tail <= (tail+k) mod QENTRIES. The pointer wraps; no separate wrap bit.
  - free_cnt <= free_cnt - k + commit_cnt, evaluated at full width and saturated at QENTRIES. An overflow is an assertion failure in simulation.
- Boundaries:
  - free_cnt=0: k=0, bundle_done=0 unless pat==0, slotv holds.
  - phit=0: no enqueue, state holds, commits are still applied.
  - Enqueue and commit in the same cycle: both are applied.
  - debug_on: exactly one slot per cycle.
  - rst while mid-bundle: returns to the reset values on the next edge.

Optional Feature:
- Macro: SCHED_PERF_EN.
- Defined: adds output ports perf_stall (32) and perf_enq (32), both cleared on rst.
  - perf_stall increments when pat!=0 & k==0 & !branchmiss.
  - perf_enq adds k every cycle.
  - Both wrap at 2^32.
- Undefined: the ports are present but tied to 0, and no counter flops are built.

Decomposition:
- Package fq_sched_pkg:
  - SLOTS=6.
  - slot_idx_t (3 bits).
  - qidx_t, parameterised through the module.
  - A min3 function.
- Sub-module fq_slot_pick, combinational: inputs pat, stop mask (slot_jc|take_branch) and lim; outputs k, qslot per way, taken mask and all_taken.
- The parent module holds all registers.

Test Plan:
- Reset, WAYS=2, phit=1, ip_mask=3F, no jc/branch, commit_cnt=0:
  - Cycle 1: qv=11, slots 0,1, qtail 0,1.
  - Cycle 2: slots 2,3.
  - Cycle 3: slots 4,5 with bundle_done=1.
  - After cycle 3: slotv=3F, free_cnt=10.
- take_branch=6'b000010, ip_mask=3F: qv=11, slots 0,1, bundle_done=1, slotv stays 3F, tail advances by 2.
- debug_on=1, ip_mask=6'b111000: slots 3, 4, 5 on three consecutive cycles, each with qv=01; bundle_done=1 on the third.
- free_cnt driven to 1, ip_mask=3F:
  - First cycle: one slot enqueued.
  - Next cycle with commit_cnt=0: k=0 and slotv holds.
  - Then commit_cnt=3: free_cnt=3 on the next cycle.
- tail=15 (QENTRIES=16) with 2 enqueued: qtail=15,0, and tail=1 afterwards.
- branchmiss mid-bundle (slotv=111100): qv=0, slotv=3F on the next cycle, tail unchanged, the same-cycle commit_cnt=2 applied to free_cnt.

Source files
------------

// File: rtl/fq_sched_pkg.sv
// Shared types and helpers for the fetch-queue scheduler.
package fq_sched_pkg;
  localparam int SLOTS = 6;

  typedef logic [2:0]       slot_idx_t;
  typedef logic [SLOTS-1:0] slot_mask_t;

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction
endpackage

// File: rtl/fq_slot_pick.sv
// Combinational slot picker: takes up to lim pending slots in ascending order,
// stopping after the first slot that redirects fetch.
module fq_slot_pick
  import fq_sched_pkg::*;
#(
  parameter int WAYS = 2
) (
  input  logic [SLOTS-1:0]  pat,
  input  logic [SLOTS-1:0]  stop,
  input  logic [2:0]        lim,
  output logic [2:0]        k,
  output logic [3*WAYS-1:0] qslot,
  output logic [SLOTS-1:0]  taken,
  output logic              all_taken,
  output logic              hit_stop
);

  logic [2:0]        cnt;
  logic              stopped;
  logic [3*WAYS-1:0] qslot_next;
  logic [SLOTS-1:0]  taken_next;

  always_comb begin
    cnt        = '0;
    stopped    = 1'b0;
    qslot_next = '0;
    taken_next = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (pat[s] && !stopped && (cnt < lim)) begin
        for (int w = 0; w < WAYS; w++) begin
          if (cnt == 3'(w)) qslot_next[w*3 +: 3] = slot_idx_t'(s);
        end
        taken_next[s] = 1'b1;
        cnt           = cnt + 3'd1;
        if (stop[s]) stopped = 1'b1;
      end
    end
  end

  assign k         = cnt;
  assign qslot     = qslot_next;
  assign taken     = taken_next;
  assign all_taken = (taken_next == pat);
  assign hit_stop  = |(taken_next & stop);

endmodule

// File: rtl/fetch_queue_sched.sv
// Fetch-bundle to instruction-queue scheduler: slot tracking, tail pointer, free count.
// Optional SCHED_PERF_EN builds stall/enqueue counters; otherwise those ports read 0.
module fetch_queue_sched
  import fq_sched_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int QENTRIES = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              branchmiss,
  input  logic                              phit,
  input  logic [SLOTS-1:0]                  ip_mask,
  input  logic [SLOTS-1:0]                  slot_jc,
  input  logic [SLOTS-1:0]                  take_branch,
  input  logic                              debug_on,
  input  logic [2:0]                        commit_cnt,
  output logic [SLOTS-1:0]                  slotv,
  output logic [WAYS-1:0]                   qv,
  output logic [3*WAYS-1:0]                 qslot,
  output logic [WAYS*$clog2(QENTRIES)-1:0]  qtail,
  output logic [$clog2(QENTRIES):0]         free_cnt,
  output logic                              bundle_done,
  output logic [31:0]                       perf_stall,
  output logic [31:0]                       perf_enq
);

  localparam int QW = $clog2(QENTRIES);
  localparam int FW = QW + 1;

  typedef logic [QW-1:0] qidx_t;

  slot_mask_t    slotv_reg, slotv_next;
  qidx_t         tail_reg, tail_next;
  logic [FW-1:0] free_cnt_reg, free_cnt_next;
  logic [FW:0]   free_sum;

  slot_mask_t        pat;
  logic [2:0]        lim;
  logic [2:0]        k_pick, k_eff;
  logic [3*WAYS-1:0] pick_qslot;
  slot_mask_t        taken;
  logic              all_taken, hit_stop;
  logic              enq_ok;

  assign pat = slotv_reg & {SLOTS{phit}} & ip_mask;
  assign lim = 3'(min3(WAYS, int'(free_cnt_reg), debug_on ? 1 : WAYS));

  fq_slot_pick #(.WAYS(WAYS)) u_pick (
    .pat       (pat),
    .stop      (slot_jc | take_branch),
    .lim       (lim),
    .k         (k_pick),
    .qslot     (pick_qslot),
    .taken     (taken),
    .all_taken (all_taken),
    .hit_stop  (hit_stop)
  );

  // A flush (or reset) cancels the whole pick, so nothing is counted as enqueued.
  assign enq_ok      = !rst && !branchmiss;
  assign k_eff       = enq_ok ? k_pick : 3'd0;
  assign bundle_done = enq_ok && phit && ((pat == '0) || all_taken || hit_stop);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign qv[gi]               = enq_ok && (k_pick > 3'(gi));
    assign qslot[gi*3 +: 3]     = qv[gi] ? pick_qslot[gi*3 +: 3] : 3'd0;
    assign qtail[gi*QW +: QW]   = qv[gi] ? qidx_t'(tail_reg + qidx_t'(gi)) : '0;
  end

  always_comb begin
    slotv_next = slotv_reg & ~taken;
    if (branchmiss || bundle_done) slotv_next = '1;
  end

  assign tail_next     = tail_reg + qidx_t'(k_eff);
  assign free_sum      = {1'b0, free_cnt_reg} + (FW+1)'(commit_cnt) - (FW+1)'(k_eff);
  assign free_cnt_next = (free_sum > (FW+1)'(QENTRIES)) ? FW'(QENTRIES) : free_sum[FW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      slotv_reg    <= '1;
      tail_reg     <= '0;
      free_cnt_reg <= FW'(QENTRIES);
    end else begin
      assert (free_sum <= (FW+1)'(QENTRIES));
      slotv_reg    <= slotv_next;
      tail_reg     <= tail_next;
      free_cnt_reg <= free_cnt_next;
    end
  end

  assign slotv    = slotv_reg;
  assign free_cnt = free_cnt_reg;

`ifdef SCHED_PERF_EN
  logic [31:0] perf_stall_reg, perf_enq_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_enq_reg   <= '0;
    end else begin
      if ((pat != '0) && (k_pick == 3'd0) && !branchmiss) perf_stall_reg <= perf_stall_reg + 32'd1;
      perf_enq_reg <= perf_enq_reg + 32'(k_eff);
    end
  end

  assign perf_stall = perf_stall_reg;
  assign perf_enq   = perf_enq_reg;
`else
  assign perf_stall = '0;
  assign perf_enq   = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_sched.sv
// Table-driven bench for fetch_queue_sched (WAYS=2, QENTRIES=16) with a scoreboard queue.
module tb_fetch_queue_sched;

  typedef struct {
    logic       phit;
    logic [5:0] ip_mask;
    logic [5:0] slot_jc;
    logic [5:0] take_branch;
    logic       debug_on;
    logic [2:0] commit_cnt;
    logic       branchmiss;
    logic [1:0] qv;
    logic [5:0] qslot;
    logic [7:0] qtail;
    logic       bd;
    logic [5:0] slotv;
    logic [4:0] free_cnt;
  } vec_t;

  logic        clk, rst, branchmiss, phit, debug_on;
  logic [5:0]  ip_mask, slot_jc, take_branch;
  logic [2:0]  commit_cnt;
  logic [5:0]  slotv;
  logic [1:0]  qv;
  logic [5:0]  qslot;
  logic [7:0]  qtail;
  logic [4:0]  free_cnt;
  logic        bundle_done;
  logic [31:0] perf_stall, perf_enq;

  int   passed = 0;
  int   total  = 0;
  vec_t vecs[29];
  vec_t sb[$];
  int   exp_enq = 0;
  int   exp_stall = 2;

  fetch_queue_sched #(.WAYS(2), .QENTRIES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .branchmiss  (branchmiss),
    .phit        (phit),
    .ip_mask     (ip_mask),
    .slot_jc     (slot_jc),
    .take_branch (take_branch),
    .debug_on    (debug_on),
    .commit_cnt  (commit_cnt),
    .slotv       (slotv),
    .qv          (qv),
    .qslot       (qslot),
    .qtail       (qtail),
    .free_cnt    (free_cnt),
    .bundle_done (bundle_done),
    .perf_stall  (perf_stall),
    .perf_enq    (perf_enq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic p, input logic [5:0] ip, input logic [5:0] jc,
                              input logic [5:0] tb, input logic dbg, input logic [2:0] cc,
                              input logic bm, input logic [1:0] eqv, input logic [5:0] eqs,
                              input logic [7:0] eqt, input logic ebd, input logic [5:0] esv,
                              input logic [4:0] efc);
    vec_t v;
    v.phit = p; v.ip_mask = ip; v.slot_jc = jc; v.take_branch = tb; v.debug_on = dbg;
    v.commit_cnt = cc; v.branchmiss = bm; v.qv = eqv; v.qslot = eqs; v.qtail = eqt;
    v.bd = ebd; v.slotv = esv; v.free_cnt = efc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    phit = v.phit; ip_mask = v.ip_mask; slot_jc = v.slot_jc; take_branch = v.take_branch;
    debug_on = v.debug_on; commit_cnt = v.commit_cnt; branchmiss = v.branchmiss;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    $display("vec %0d: qv=%b qslot=%h qtail=%h done=%b", idx, qv, qslot, qtail, bundle_done);
    chk($sformatf("qv[%0d]", idx), int'(qv), int'(e.qv));
    chk($sformatf("qslot[%0d]", idx), int'(qslot), int'(e.qslot));
    chk($sformatf("qtail[%0d]", idx), int'(qtail), int'(e.qtail));
    chk($sformatf("bundle_done[%0d]", idx), int'(bundle_done), int'(e.bd));
    @(posedge clk);
    #1;
    chk($sformatf("slotv[%0d]", idx), int'(slotv), int'(e.slotv));
    chk($sformatf("free_cnt[%0d]", idx), int'(free_cnt), int'(e.free_cnt));
  endtask

  initial begin
    //               phit ip     jc     tb     dbg cc bm  | qv  qslot  qtail  bd slotv  free
    vecs[0]  = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h08, 8'h10, 0, 6'h3C, 14);
    vecs[1]  = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h1A, 8'h32, 0, 6'h30, 12);
    vecs[2]  = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h2C, 8'h54, 1, 6'h3F, 10);
    vecs[3]  = mk(1, 6'h3F, 6'h00, 6'h02, 0, 0, 0, 2'd3, 6'h08, 8'h76, 1, 6'h3F, 8);
    vecs[4]  = mk(1, 6'h38, 6'h00, 6'h00, 1, 0, 0, 2'd1, 6'h03, 8'h08, 0, 6'h37, 7);
    vecs[5]  = mk(1, 6'h38, 6'h00, 6'h00, 1, 0, 0, 2'd1, 6'h04, 8'h09, 0, 6'h27, 6);
    vecs[6]  = mk(1, 6'h38, 6'h00, 6'h00, 1, 0, 0, 2'd1, 6'h05, 8'h0A, 1, 6'h3F, 5);
    vecs[7]  = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h08, 8'hCB, 0, 6'h3C, 3);
    vecs[8]  = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h1A, 8'hED, 0, 6'h30, 1);
    vecs[9]  = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd1, 6'h04, 8'h0F, 0, 6'h20, 0);
    vecs[10] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd0, 6'h00, 8'h00, 0, 6'h20, 0);
    vecs[11] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 3, 0, 2'd0, 6'h00, 8'h00, 0, 6'h20, 3);
    vecs[12] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd1, 6'h05, 8'h00, 1, 6'h3F, 2);
    vecs[13] = mk(0, 6'h3F, 6'h00, 6'h00, 0, 6, 0, 2'd0, 6'h00, 8'h00, 0, 6'h3F, 8);
    vecs[14] = mk(0, 6'h3F, 6'h00, 6'h00, 0, 6, 0, 2'd0, 6'h00, 8'h00, 0, 6'h3F, 14);
    vecs[15] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h08, 8'h21, 0, 6'h3C, 14);
    vecs[16] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h1A, 8'h43, 0, 6'h30, 14);
    vecs[17] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h2C, 8'h65, 1, 6'h3F, 14);
    vecs[18] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h08, 8'h87, 0, 6'h3C, 14);
    vecs[19] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h1A, 8'hA9, 0, 6'h30, 14);
    vecs[20] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h2C, 8'hCB, 1, 6'h3F, 14);
    vecs[21] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h08, 8'hED, 0, 6'h3C, 14);
    vecs[22] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 0, 2'd3, 6'h1A, 8'h0F, 0, 6'h30, 14);
    vecs[23] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h2C, 8'h21, 1, 6'h3F, 12);
    vecs[24] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h08, 8'h43, 0, 6'h3C, 10);
    vecs[25] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 2, 1, 2'd0, 6'h00, 8'h00, 0, 6'h3F, 12);
    vecs[26] = mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h08, 8'h65, 0, 6'h3C, 10);
    vecs[27] = mk(1, 6'h3F, 6'h04, 6'h00, 0, 0, 0, 2'd1, 6'h02, 8'h07, 1, 6'h3F, 9);
    vecs[28] = mk(1, 6'h00, 6'h00, 6'h00, 0, 0, 0, 2'd0, 6'h00, 8'h00, 1, 6'h3F, 9);

    // Reset with an otherwise-active bundle on the inputs.
    rst = 1'b1;
    drive(mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_qv", int'(qv), 0);
    chk("reset_bundle_done", int'(bundle_done), 0);
    chk("reset_slotv", int'(slotv), 'h3F);
    chk("reset_free_cnt", int'(free_cnt), 16);
    phit = 1'b0;
    rst  = 1'b0;

    foreach (vecs[i]) begin
      run_vec(i, vecs[i]);
      exp_enq += int'(vecs[i].qv[0]) + int'(vecs[i].qv[1]);
    end

`ifndef SCHED_PERF_EN
    exp_enq   = 0;
    exp_stall = 0;
`endif
    chk("perf_enq", int'(perf_enq), exp_enq);
    chk("perf_stall", int'(perf_stall), exp_stall);

    // Reset in the middle of a bundle: state returns to reset values.
    run_vec(29, mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h08, 8'h98, 0, 6'h3C, 7));
    @(negedge clk);
    rst = 1'b1;
    #2;
    $display("midreset: qv=%b done=%b", qv, bundle_done);
    chk("midreset_qv", int'(qv), 0);
    chk("midreset_bundle_done", int'(bundle_done), 0);
    @(posedge clk);
    #1;
    chk("midreset_slotv", int'(slotv), 'h3F);
    chk("midreset_free_cnt", int'(free_cnt), 16);
    @(negedge clk);
    rst = 1'b0;
    phit = 1'b0;
    run_vec(30, mk(1, 6'h3F, 6'h00, 6'h00, 0, 0, 0, 2'd3, 6'h08, 8'h10, 0, 6'h3C, 14));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
